mac_tx_fifo: RTL and testbench

//  Egress byte buffer between the dataplane rewrite stage and the MAC transmitter. Stores

---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_tx_ram.sv | 23 ++
 rtl/mac_tx_fifo.sv | 186 ++++++++++++++++++
 tb/tb_mac_tx_fifo.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC types and constants for the TX and RX datapaths
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    PAD,
    GAP
  } tx_state_e;

  localparam int         MAC_MIN_FRAME   = 60;
  localparam int         MAC_IFG_DEFAULT = 12;
  localparam logic [7:0] PAD_BYTE        = 8'h00;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mac_tx_ram.sv
// rtl/mac_tx_ram.sv - DEPTH x 9-bit frame byte store, one write port, one async read port
module mac_tx_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [8:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [8:0]        rd_data
);

  // Word layout is {last, data}.
  logic [8:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mac_tx_fifo.sv
// rtl/mac_tx_fifo.sv - store-and-forward egress byte FIFO toward the MAC with inter-frame gap
// Optional MAC_TX_PAD_EN: zero-pads short frames up to MIN_FRAME bytes.
module mac_tx_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6,
  parameter int IFG_CYCLES = MAC_IFG_DEFAULT,
  parameter int MIN_FRAME  = MAC_MIN_FRAME
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  input  logic            in_last,
  output logic            in_ready,
  output logic            tx_valid,
  output logic [7:0]      tx_data,
  output logic            tx_last,
  input  logic            tx_ready,
  output logic            tx_fire,
  output logic [ADDR_W:0] frames_queued,
  output logic            underrun_err
);

  if (DEPTH != (1 << ADDR_W) || DEPTH < 16 || IFG_CYCLES < 1 || IFG_CYCLES > 255 ||
      MIN_FRAME < 1 || MIN_FRAME > 65535) begin : g_bad_params
    $error("mac_tx_fifo: illegal parameter set");
  end

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W + 1)'(1);
  localparam logic [7:0]      IFG_LOAD = 8'(IFG_CYCLES);

  tx_state_e       state, state_n;
  logic [ADDR_W:0] wr_ptr, rd_ptr, count;
  logic [7:0]      gap_cnt, gap_cnt_n;
  logic [15:0]     byte_cnt, byte_cnt_n, head_cnt;
  logic [8:0]      rd_word;
  logic            push, pop, frame_add, frame_ret, end_frame, launch;
  logic            tx_valid_n, tx_last_n, underrun_n;
  logic [7:0]      tx_data_n;

  mac_tx_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data ({in_last, in_data}),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_word)
  );

  assign in_ready  = (count < FULL_CNT);
  assign push      = in_valid && in_ready;
  assign frame_add = push && in_last;
  assign tx_fire   = tx_valid && tx_ready;
  assign head_cnt  = sat_inc16(byte_cnt);
  // A full FIFO with no complete frame must still launch, or an oversized frame deadlocks.
  assign launch    = (frames_queued != '0) || (count == FULL_CNT);

  always_comb begin
    state_n    = state;
    gap_cnt_n  = gap_cnt;
    byte_cnt_n = byte_cnt;
    tx_valid_n = tx_valid;
    tx_data_n  = tx_data;
    tx_last_n  = tx_last;
    underrun_n = 1'b0;
    pop        = 1'b0;
    frame_ret  = 1'b0;
    end_frame  = 1'b0;

    case (state)
      IDLE: begin
        if (launch) begin
          pop     = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (tx_fire && tx_last) begin
          end_frame = 1'b1;
`ifndef MAC_TX_PAD_EN
          frame_ret = 1'b1;
`endif
        end else if (tx_fire || !tx_valid) begin
          if (count != '0) begin
            pop = 1'b1;
          end else begin
            tx_valid_n = 1'b0;
            underrun_n = tx_fire;
          end
        end
      end
      PAD: begin
`ifdef MAC_TX_PAD_EN
        if (tx_fire) begin
          if (tx_last) begin
            end_frame = 1'b1;
          end else begin
            tx_data_n  = PAD_BYTE;
            tx_last_n  = (head_cnt >= 16'(MIN_FRAME));
            byte_cnt_n = head_cnt;
          end
        end
`else
        state_n = IDLE;
`endif
      end
      GAP: begin
        tx_valid_n = 1'b0;
        if (gap_cnt <= 8'd1) begin
          // Final gap cycle doubles as IDLE so the idle run is exactly IFG_CYCLES long.
          gap_cnt_n = 8'd0;
          state_n   = IDLE;
          if (launch) begin
            pop     = 1'b1;
            state_n = SEND;
          end
        end else begin
          gap_cnt_n = gap_cnt - 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (pop) begin
      tx_valid_n = 1'b1;
      tx_data_n  = rd_word[7:0];
      tx_last_n  = rd_word[8];
      byte_cnt_n = head_cnt;
`ifdef MAC_TX_PAD_EN
      frame_ret = rd_word[8];
      if (rd_word[8] && (head_cnt < 16'(MIN_FRAME))) begin
        tx_last_n = 1'b0;
        state_n   = PAD;
      end
`endif
    end

    if (end_frame) begin
      tx_valid_n = 1'b0;
      tx_last_n  = 1'b0;
      gap_cnt_n  = IFG_LOAD;
      byte_cnt_n = 16'd0;
      state_n    = GAP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      frames_queued <= '0;
      gap_cnt       <= 8'd0;
      byte_cnt      <= 16'd0;
      tx_valid      <= 1'b0;
      tx_data       <= PAD_BYTE;
      tx_last       <= 1'b0;
      underrun_err  <= 1'b0;
    end else begin
      state        <= state_n;
      gap_cnt      <= gap_cnt_n;
      byte_cnt     <= byte_cnt_n;
      tx_valid     <= tx_valid_n;
      tx_data      <= tx_data_n;
      tx_last      <= tx_last_n;
      underrun_err <= underrun_n;
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      case ({frame_add, frame_ret})
        2'b10:   frames_queued <= frames_queued + ONE;
        2'b01:   frames_queued <= frames_queued - ONE;
        default: frames_queued <= frames_queued;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_fifo.sv
// tb/tb_mac_tx_fifo.sv - directed self-checking bench for mac_tx_fifo
module tb_mac_tx_fifo;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int IFG    = 12;
  localparam int MINF   = 60;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [7:0]      in_data = 8'h00;
  logic            in_last = 1'b0;
  logic            in_ready;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_last;
  logic            tx_ready = 1'b0;
  logic            tx_fire;
  logic [ADDR_W:0] frames_queued;
  logic            underrun_err;

  mac_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .IFG_CYCLES(IFG), .MIN_FRAME(MINF)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_last       (tx_last),
    .tx_ready      (tx_ready),
    .tx_fire       (tx_fire),
    .frames_queued (frames_queued),
    .underrun_err  (underrun_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] rx_data [$];
  logic       rx_last [$];
  int         rx_cyc  [$];
  int         under_cnt  = 0;
  int         fq_at_last = -1;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word  = 9'h0;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        expect_eq("stall_valid", 32'(tx_valid), 32'd1);
        expect_eq("stall_hold", 32'({tx_last, tx_data}), 32'(prev_word));
      end
      if (tx_fire) begin
        rx_data.push_back(tx_data);
        rx_last.push_back(tx_last);
        rx_cyc.push_back(cyc);
        if (tx_last) fq_at_last = int'(frames_queued);
      end
      if (underrun_err) under_cnt++;
      prev_stall = tx_valid && !tx_ready;
      prev_word  = {tx_last, tx_data};
    end
  end

  function automatic int out_len(input int len);
`ifdef MAC_TX_PAD_EN
    return (len < MINF) ? MINF : len;
`else
    return len;
`endif
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_last.delete();
    rx_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) expect_eq("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] base, input int len, input logic with_last);
    for (int i = 0; i < len; i++) send_byte(base + 8'(i), with_last && (i == len - 1));
  endtask

  task automatic wait_rx(input int n, input string tag);
    int g = 0;
    while (rx_data.size() < n && g < 600) begin
      @(posedge clk);
      #1;
      g++;
    end
    expect_eq(tag, 32'(rx_data.size()), 32'(n));
  endtask

  task automatic check_frame(input string tag, input int first, input logic [7:0] base, input int len);
    int olen = out_len(len);
    for (int i = 0; i < olen; i++) begin
      expect_eq({tag, "_data"}, 32'(rx_data[first + i]), (i < len) ? 32'(base + 8'(i)) : 32'h0);
      expect_eq({tag, "_last"}, 32'(rx_last[first + i]), 32'(i == olen - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int last_acc;
  int o1, o2;

  initial begin
    idle(3);
    expect_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    expect_eq("rst_tx_last", 32'(tx_last), 32'd0);
    expect_eq("rst_tx_data", 32'(tx_data), 32'h00);
    expect_eq("rst_fq", 32'(frames_queued), 32'd0);
    expect_eq("rst_underrun", 32'(underrun_err), 32'd0);
    rst_n = 1'b1;
    idle(2);
    expect_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: 8-byte frame, MAC always ready
    clear_rx();
    tx_ready = 1'b1;
    push_frame(8'h01, 8, 1'b1);
    last_acc = cyc;
    expect_eq("t1_no_early", 32'(rx_data.size()), 32'd0);
    wait_rx(out_len(8), "t1_count");
    expect_eq("t1_latency", 32'(rx_cyc[0]), 32'(last_acc + 1));
    for (int i = 1; i < 8; i++) expect_eq("t1_back2back", 32'(rx_cyc[i]), 32'(rx_cyc[0] + i));
    check_frame("t1", 0, 8'h01, 8);
    idle(IFG + 2);
    expect_eq("t1_no_extra", 32'(rx_data.size()), 32'(out_len(8)));
    expect_eq("t1_fq", 32'(frames_queued), 32'd0);

    // 2: 20-byte frame under alternating backpressure
    clear_rx();
    tx_ready = 1'b0;
    push_frame(8'h20, 20, 1'b1);
    expect_eq("t2_fq_one", 32'(frames_queued), 32'd1);
    for (int i = 0; i < 200 && rx_data.size() < out_len(20); i++) begin
      @(posedge clk);
      #1;
      tx_ready = ~tx_ready;
    end
    wait_rx(out_len(20), "t2_count");
    idle(1);
    expect_eq("t2_fq_at_last", 32'(fq_at_last), 32'd1);
    expect_eq("t2_fq_after", 32'(frames_queued), 32'd0);
    check_frame("t2", 0, 8'h20, 20);
    tx_ready = 1'b1;
    idle(IFG + 4);

    // 3: fill to DEPTH with no frame end, cut-through drain, underrun, resume
    clear_rx();
    tx_ready  = 1'b0;
    under_cnt = 0;
    push_frame(8'h40, DEPTH, 1'b0);
    expect_eq("t3_full_in_ready", 32'(in_ready), 32'd0);
    idle(2);
    expect_eq("t3_cut_valid", 32'(tx_valid), 32'd1);
    expect_eq("t3_cut_data", 32'(tx_data), 32'h40);
    tx_ready = 1'b1;
    wait_rx(DEPTH, "t3_drain_count");
    idle(3);
    expect_eq("t3_underrun_pulses", 32'(under_cnt), 32'd1);
    expect_eq("t3_valid_low", 32'(tx_valid), 32'd0);
    expect_eq("t3_in_ready", 32'(in_ready), 32'd1);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b1);
    wait_rx(DEPTH + 2, "t3_resume_count");
    idle(2);
    for (int i = 0; i < DEPTH; i++) begin
      expect_eq("t3_data", 32'(rx_data[i]), 32'(8'h40 + 8'(i)));
      expect_eq("t3_last", 32'(rx_last[i]), 32'd0);
    end
    expect_eq("t3_a1", 32'({rx_last[DEPTH], rx_data[DEPTH]}), 32'h0A1);
    expect_eq("t3_a2", 32'({rx_last[DEPTH + 1], rx_data[DEPTH + 1]}), 32'h1A2);
    expect_eq("t3_underrun_final", 32'(under_cnt), 32'd1);
    expect_eq("t3_fq", 32'(frames_queued), 32'd0);
    idle(IFG + 4);

    // 4: three short frames queued, then drained with gaps
    clear_rx();
    tx_ready = 1'b0;
    push_frame(8'hB0, 5, 1'b1);
    push_frame(8'hC0, 5, 1'b1);
    push_frame(8'hD0, 5, 1'b1);
    expect_eq("t4_fq_peak", 32'(frames_queued), 32'd3);
    tx_ready = 1'b1;
    o1 = out_len(5);
    wait_rx(3 * o1, "t4_count");
    check_frame("t4a", 0, 8'hB0, 5);
    check_frame("t4b", o1, 8'hC0, 5);
    check_frame("t4c", 2 * o1, 8'hD0, 5);
    expect_eq("t4_gap1", 32'(rx_cyc[o1] - rx_cyc[o1 - 1]), 32'(IFG + 1));
    expect_eq("t4_gap2", 32'(rx_cyc[2 * o1] - rx_cyc[2 * o1 - 1]), 32'(IFG + 1));
    idle(2);
    expect_eq("t4_fq_end", 32'(frames_queued), 32'd0);
    idle(IFG + 4);

    // 5: short frame length handling
    clear_rx();
    push_frame(8'hE0, 10, 1'b1);
    o2 = out_len(10);
    wait_rx(o2, "t5_count");
    idle(4);
    expect_eq("t5_exact_len", 32'(rx_data.size()), 32'(o2));
    check_frame("t5", 0, 8'hE0, 10);
    idle(IFG + 4);

    // 6: reset asserted mid-SEND
    clear_rx();
    tx_ready = 1'b0;
    push_frame(8'h60, 8, 1'b1);
    idle(2);
    expect_eq("t6_sending", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    idle(1);
    rst_n = 1'b0;
    #1;
    expect_eq("t6_rst_valid", 32'(tx_valid), 32'd0);
    expect_eq("t6_rst_fq", 32'(frames_queued), 32'd0);
    idle(1);
    rst_n = 1'b1;
    expect_eq("t6_in_ready", 32'(in_ready), 32'd1);
    idle(5);
    expect_eq("t6_no_resume", 32'(tx_valid), 32'd0);
    clear_rx();
    push_frame(8'h70, 3, 1'b1);
    wait_rx(out_len(3), "t6_post_count");
    check_frame("t6", 0, 8'h70, 3);
    idle(IFG + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
